// File: rtl/f_pkg.sv
// Shared types and constants for the FP32 adder normalization back end.
package f_pkg;
    localparam int FRAC_W  = 23;
    localparam int EXP_W   = 8;
    localparam int SUM_W   = FRAC_W + 2;
    localparam int LZ_W    = 5;
    localparam int BIAS    = 127;
    localparam int EXP_MAX = 255;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

    typedef struct packed {
        logic zero;
        logic ovf;
        logic unf;
    } norm_flags_t;

    // Stage-1 register: operand plus the already-clamped left-shift amount.
    typedef struct packed {
        logic             sign;
        logic             unf;
        logic [EXP_W-1:0] exp;
        logic [LZ_W-1:0]  shamt;
        logic [SUM_W-1:0] mant;
    } norm_s1_t;
endpackage

// File: rtl/f_lzc24.sv
// 24-bit leading-zero counter, log-depth pairwise tree; returns 24 for zero input.
module f_lzc24 (
    input  logic [23:0] a,
    output logic [4:0]  cnt
);
    // Padding with ones makes an all-zero input count to exactly 24.
    logic [31:0] v;
    assign v = {a, 8'hFF};

    logic [15:0]      z0, c0;
    logic [7:0]       z1;
    logic [7:0][1:0]  c1;
    logic [3:0]       z2;
    logic [3:0][2:0]  c2;
    logic             z3_hi;
    logic [1:0][3:0]  c3;

    for (genvar i = 0; i < 16; i++) begin : g_l0
        assign z0[i] = ~|v[2*i +: 2];
        assign c0[i] = ~v[2*i+1];
    end

    for (genvar i = 0; i < 8; i++) begin : g_l1
        assign z1[i] = z0[2*i+1] & z0[2*i];
        assign c1[i] = z0[2*i+1] ? {1'b1, c0[2*i]} : {1'b0, c0[2*i+1]};
    end

    for (genvar i = 0; i < 4; i++) begin : g_l2
        assign z2[i] = z1[2*i+1] & z1[2*i];
        assign c2[i] = z1[2*i+1] ? {1'b1, c1[2*i]} : {1'b0, c1[2*i+1]};
    end

    for (genvar i = 0; i < 2; i++) begin : g_l3
        assign c3[i] = z2[2*i+1] ? {1'b1, c2[2*i]} : {1'b0, c2[2*i+1]};
    end
    assign z3_hi = z2[3] & z2[2];

    assign cnt = z3_hi ? {1'b1, c3[0]} : {1'b0, c3[1]};
endmodule

// File: rtl/f_normalize_pipe.sv
// FP32 post-add normalization: LZC/shift-clamp in stage 1, pack and flag in stage 2.
module f_normalize_pipe #(
    parameter int FRAC_W = 23,
    parameter int EXP_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_sign,
    input  logic [EXP_W-1:0]  in_exp,
    input  logic [FRAC_W+1:0] in_mant,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic              out_zero,
    output logic              out_ovf,
    output logic              out_unf
);
    import f_pkg::*;

    logic [2:1]  vld_pipe;
    logic        s1_adv, s2_adv;
    norm_s1_t    s1_d, s1_q;
    fp32_t       res_d, res_q;
    norm_flags_t flg_d, flg_q;

    assign s2_adv    = !vld_pipe[2] || out_ready;
    assign s1_adv    = !vld_pipe[1] || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = vld_pipe[2];
    assign out_word  = res_q;
    assign out_zero  = flg_q.zero;
    assign out_ovf   = flg_q.ovf;
    assign out_unf   = flg_q.unf;

    // ---------------- stage 1 ----------------
    logic [4:0]       lz;
    logic [EXP_W-1:0] exp_eff, exp_m1;
    logic             deep;

    f_lzc24 u_lzc (
        .a   (in_mant[FRAC_W:0]),
        .cnt (lz)
    );

    // Shift is capped at exp-1 so the exponent never drops below 1;
    // a capped shift means the result lands in the subnormal range.
    assign exp_eff = (in_exp == '0) ? EXP_W'(1) : in_exp;
    assign exp_m1  = exp_eff - EXP_W'(1);
    assign deep    = {{(EXP_W-5){1'b0}}, lz} > exp_m1;

    always_comb begin
        s1_d       = '0;
        s1_d.sign  = in_sign;
        s1_d.exp   = exp_eff;
        s1_d.mant  = in_mant;
        s1_d.shamt = deep ? exp_m1[4:0] : lz;
        s1_d.unf   = deep && !in_mant[FRAC_W+1] && (in_mant != '0);
    end

    // ---------------- stage 2 ----------------
    logic [EXP_W:0]    exp_n;
    logic [FRAC_W-1:0] sh_frac;

    always_comb begin
        exp_n     = {1'b0, s1_q.exp} + 9'd1;
        sh_frac   = s1_q.mant[FRAC_W-1:0] << s1_q.shamt;
        res_d     = '0;
        flg_d     = '0;
        res_d.sign = s1_q.sign;
        if (s1_q.mant == '0) begin
            res_d.sign = 1'b0;
            flg_d.zero = 1'b1;
        end else if (s1_q.mant[FRAC_W+1]) begin
            if (exp_n >= 9'(EXP_MAX)) begin
                res_d.exp = '1;
                flg_d.ovf = 1'b1;
            end else begin
                res_d.exp  = exp_n[EXP_W-1:0];
                res_d.frac = s1_q.mant[FRAC_W:1];
            end
        end else if (s1_q.unf) begin
            res_d.frac = sh_frac;
            flg_d.unf  = 1'b1;
        end else begin
            res_d.exp  = s1_q.exp - {{(EXP_W-5){1'b0}}, s1_q.shamt};
            res_d.frac = sh_frac;
        end
    end

    // Output registers only load on a real beat so they hold across stalls and bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            s1_q     <= '0;
            res_q    <= '0;
            flg_q    <= '0;
        end else begin
            if (s1_adv) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) s1_q <= s1_d;
            end
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    res_q <= res_d;
                    flg_q <= flg_d;
                end
            end
        end
    end
endmodule

// File: tb/tb_f_normalize_pipe.sv
// Randomized scoreboard bench for f_normalize_pipe against an arithmetic reference model.
module tb_f_normalize_pipe;
    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_sign;
    logic        out_valid, out_ready, out_zero, out_ovf, out_unf;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic [31:0] out_word;

    always #5 clk = ~clk;

    f_normalize_pipe dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_word(out_word), .out_zero(out_zero), .out_ovf(out_ovf), .out_unf(out_unf)
    );

    typedef struct {
        logic [31:0] word;
        logic [2:0]  flg;   // {zero, ovf, unf}
    } res_t;

    res_t q[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   idle  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Value-level model: find the leading one, shift and rebias as the number line dictates.
    function automatic res_t ref_norm(input logic s, input logic [7:0] e_in, input logic [24:0] m);
        res_t        r;
        int          e, lz;
        logic [23:0] f;
        e     = (e_in == 8'd0) ? 1 : int'(e_in);
        r.flg = 3'b000;
        r.word = 32'h0;
        if (m == 25'd0) begin
            r.flg = 3'b100;
        end else if (m[24]) begin
            if (e + 1 >= 255) begin
                r.word = {s, 8'hFF, 23'h0};
                r.flg  = 3'b010;
            end else begin
                r.word = {s, 8'(e + 1), m[23:1]};
            end
        end else begin
            lz = 0;
            while (!m[23 - lz]) lz++;
            if (lz <= e - 1) begin
                f = m[23:0] << lz;
                r.word = {s, 8'(e - lz), f[22:0]};
            end else begin
                f = m[23:0] << (e - 1);
                r.word = {s, 8'h00, f[22:0]};
                r.flg  = 3'b001;
            end
        end
        return r;
    endfunction

    // One clock: drive at negedge, check outputs mid-cycle, update scoreboard for the coming edge.
    task automatic cycle(input logic v, input logic s, input logic [7:0] e,
                         input logic [24:0] m, input logic rdy);
        @(negedge clk);
        in_valid = v; in_sign = s; in_exp = e; in_mant = m; out_ready = rdy;
        #1;
        chk("in_ready", 32'(in_ready), 32'(rdy || q.size() < 2));
        if (out_valid) begin
            idle = 0;
            if (q.size() == 0) begin
                chk("spurious_valid", 32'(out_valid), 32'd0);
            end else begin
                chk("word", out_word, q[0].word);
                chk("flags", 32'({out_zero, out_ovf, out_unf}), 32'(q[0].flg));
                if (rdy) void'(q.pop_front());
            end
        end else if (q.size() != 0) begin
            idle++;
            if (idle > 3) begin
                chk("out_valid_timeout", 32'(idle), 32'd0);
                idle = 0;
            end
        end
        if (v && in_ready) q.push_back(ref_norm(s, e, m));
    endtask

    task automatic apply_reset(input int edges);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (edges) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_word", out_word, 32'h0);
        chk("rst_flags", 32'({out_zero, out_ovf, out_unf}), 32'd0);
        reset = 1'b0;
        q.delete();
        idle = 0;
    endtask

    function automatic logic [24:0] rnd_mant();
        int          k;
        logic [24:0] m;
        k = $urandom_range(0, 9);
        m = 25'($urandom);
        if (k == 0)      m = 25'd0;
        else if (k <= 2) m = m | 25'h1000000;
        else             m = {1'b0, m[23:0]} >> $urandom_range(0, 24);
        return m;
    endfunction

    function automatic logic [7:0] rnd_exp();
        int k;
        k = $urandom_range(0, 5);
        if (k == 0)      return 8'($urandom_range(0, 8));
        else if (k == 1) return 8'($urandom_range(250, 254));
        else             return 8'($urandom_range(1, 254));
    endfunction

    logic [24:0] d_mant [6] = '{25'h0800000, 25'h1000000, 25'h0000001, 25'h0000100, 25'h1000000, 25'h0000000};
    logic [7:0]  d_exp  [6] = '{8'h80, 8'h7F, 8'h7F, 8'h05, 8'hFE, 8'h00};
    logic        d_sign [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] d_word [6] = '{32'h40000000, 32'h40000000, 32'hB4000000, 32'h00001000, 32'hFF800000, 32'h00000000};

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
        apply_reset(2);

        // Model sanity against hand-derived words.
        for (int i = 0; i < 6; i++)
            chk("model_vec", ref_norm(d_sign[i], d_exp[i], d_mant[i]).word, d_word[i]);

        // Latency: accept, one edge in s1 only, second edge presents the result.
        cycle(1'b1, 1'b0, 8'h80, 25'h0800000, 1'b1);
        cycle(1'b0, 1'b0, 8'h00, 25'h0, 1'b1);
        chk("lat_edge1", 32'(out_valid), 32'd0);
        cycle(1'b0, 1'b0, 8'h00, 25'h0, 1'b1);
        chk("lat_edge2", 32'(out_valid), 32'd1);

        // Directed vectors back to back, then drain.
        for (int i = 0; i < 6; i++) cycle(1'b1, d_sign[i], d_exp[i], d_mant[i], 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 25'h0, 1'b1);

        // Backpressure: zero beat plus two more while downstream is stalled.
        cycle(1'b1, 1'b1, 8'h10, 25'h0000000, 1'b0);
        cycle(1'b1, 1'b0, 8'h80, 25'h0C00000, 1'b0);
        cycle(1'b1, 1'b0, 8'h7F, 25'h1800000, 1'b0);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        cycle(1'b1, 1'b0, 8'h7F, 25'h1800000, 1'b0);
        chk("bp_zero_word", out_word, 32'h0);
        chk("bp_zero_flag", 32'(out_zero), 32'd1);
        repeat (5) cycle(1'b1, 1'b0, 8'h7F, 25'h1800000, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 8'h00, 25'h0, 1'b1);

        // Reset mid-stall clears the pipe after a single edge.
        cycle(1'b1, 1'b0, 8'h90, 25'h0400000, 1'b0);
        cycle(1'b1, 1'b0, 8'h91, 25'h0200000, 1'b0);
        repeat (2) cycle(1'b0, 1'b0, 8'h00, 25'h0, 1'b0);
        apply_reset(1);

        // Random traffic with random backpressure.
        for (int i = 0; i < 3000; i++)
            cycle($urandom_range(0, 3) != 0, 1'($urandom), rnd_exp(), rnd_mant(),
                  $urandom_range(0, 3) != 0);
        repeat (6) cycle(1'b0, 1'b0, 8'h00, 25'h0, 1'b1);
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
